cp_inserter: RTL and testbench
==============================

Name: cp_inserter

Overview:
Transmit-side cyclic-prefix inserter for the OFDM chain. It sits between the IFFT output and the DAC/framing stage.
- Accepts N-sample time-domain symbols on a valid/ready stream.
- Buffers each symbol in a ping-pong store.
- Emits CP+N samples per symbol: the last CP samples first, then the full symbol.
- It is the transmit counterpart of the receiver's N-cycle delay and CP-correlation path.

Parameters:
- D, 16, sample width in bits (packed I/Q word, opaque to the block).
- N, 64, symbol length in samples (FFT size); power of two, at least 4.
- CP, 16, cyclic-prefix length; 1 <= CP < N.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  D  IFFT output sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample this cycle.
- out_data  output  D  transmitted sample (prefix or body).
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, in_ready=1. Both bank-full flags are cleared, write and read pointers are 0, write bank is 0, FSM is IDLE.
- Input handshake: a transfer occurs when in_valid && in_ready at a rising edge.
  - Sample i of the symbol (i = 0..N-1) is written to mem[wbank][i] and the write counter increments.
  - On the N-th transfer, full[wbank] is set, wbank toggles, and the write counter wraps to 0 at the same edge.
- in_ready = !full[wbank], driven combinationally from registers. It does not depend on in_valid.
- Output handshake: a transfer occurs when out_valid && out_ready at a rising edge. While out_valid=1 && out_ready=0, out_data and out_valid hold stable.
- Read FSM states and transitions:
  - IDLE: if full[rbank], load out_data=mem[rbank][N-CP], set out_valid=1, rptr=N-CP+1, go to PREFIX. Otherwise out_valid=0.
  - PREFIX: on each output transfer, load mem[rbank][rptr] and increment rptr. When the transfer takes index N-1, load mem[rbank][0], set rptr=1, go to BODY.
  - BODY: on each output transfer, load mem[rbank][rptr] and increment rptr. On transfer of index N-1:
    - clear full[rbank] and toggle rbank;
    - if full[other bank] is already set, load its mem[N-CP] directly and re-enter PREFIX with no bubble;
    - otherwise drop out_valid and go to IDLE.
- Latency: if the N-th input transfer occurs at edge k, the first prefix sample is valid after edge k+1, provided the reader was IDLE.
- Throughput: with out_ready held at 1, exactly CP+N consecutive output beats per symbol. Input is back-pressured only when both banks are full.
- Simultaneous events: the writer setting full[x] and the reader clearing full[y] in the same cycle is legal, since x != y is guaranteed. If both touch the same flag, clear takes priority; this cannot occur in correct operation and is flagged by an assertion.
- Reset mid-operation: any partial symbol and pending outputs are discarded. The block restarts at sample 0 of bank 0.
- Index arithmetic: pointers are $clog2(N) bits unsigned. Prefix start N-CP is computed as a constant.

Optional Feature:
- Macro: CPI_FLAGS_EN.
- Defined: adds output ports out_sos (high on the first prefix beat of each symbol), out_eos (high on the last body beat), and out_in_cp (high on all CP prefix beats). All three are qualified by out_valid, reset to 0, and held together with out_data under back-pressure.
- Undefined: these ports and their registers do not exist. Core behaviour is identical.

Decomposition:
- Package ofdm_tx_pkg:
  - default N, CP, D;
  - pointer width PTR_W=$clog2(N);
  - constant CP_START=N-CP;
  - read-FSM state enum {IDLE, PREFIX, BODY}.
- Sub-module cpi_symbol_buf: two-bank register array of 2xN words of width D. One write port (bank, addr, data, we) and one asynchronous read port (bank, addr). The top level holds flags, pointers, FSM and output register.

Test Plan:
- Single symbol with in_valid=1 and out_ready=1, samples 0..63 → out_valid from edge k+1. Output sequence is 48..63 then 0..63 (80 beats), then out_valid=0.
- Three back-to-back symbols with values s*100+i → 240 contiguous output beats with no bubble. in_ready drops while both banks are full, and no input sample is lost.
- Random out_ready at 50% → out_data stable whenever out_ready=0. Each symbol is still ordered as 48..63, 0..63.
- Assert rst after 30 input samples of a symbol → after the reset edge, out_valid=0 and in_ready=1. The next 64-sample symbol is output correctly with no residue from the aborted one.
- Parameter run with N=16, CP=4 and input 0..15 → output 12..15, 0..15 (20 beats).
- With CPI_FLAGS_EN, standard symbol → out_sos on beat 0 only, out_in_cp on beats 0..15, out_eos on beat 79 only.

Source files
------------

// File: rtl/ofdm_tx_pkg.sv
// ofdm_tx_pkg
// Shared definitions for the transmit-side OFDM blocks.
//   DEF_D / DEF_N / DEF_CP : default sample width, symbol length, prefix length
//   PTR_W                  : sample-pointer width for the default symbol length
//   CP_START               : first prefix index for the default configuration
//   rd_state_t             : read-side state of the cyclic-prefix inserter
package ofdm_tx_pkg;

   localparam int DEF_D    = 16;
   localparam int DEF_N    = 64;
   localparam int DEF_CP   = 16;

   localparam int PTR_W    = $clog2(DEF_N);
   localparam int CP_START = DEF_N - DEF_CP;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREFIX = 2'd1,
      BODY   = 2'd2
   } rd_state_t;

endpackage

// File: rtl/cpi_symbol_buf.sv
// cpi_symbol_buf
// Two-bank symbol store for the cyclic-prefix inserter: 2 x N words of D bits.
//   clk      : write clock
//   we       : write enable
//   wr_bank  : bank written when we is high
//   wr_addr  : sample index written
//   wr_data  : sample written
//   rd_bank  : bank read (asynchronous)
//   rd_addr  : sample index read (asynchronous)
//   rd_data  : word at [rd_bank][rd_addr]
module cpi_symbol_buf
   import ofdm_tx_pkg::*;
#(
   parameter int D  = DEF_D,
   parameter int N  = DEF_N,
   parameter int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          wr_bank,
   input  logic [AW-1:0] wr_addr,
   input  logic [D-1:0]  wr_data,
   input  logic          rd_bank,
   input  logic [AW-1:0] rd_addr,
   output logic [D-1:0]  rd_data
);

   logic [D-1:0] mem [2][N];

   // Storage carries no reset: a bank is only read after its full flag is set,
   // which means every word in it has been written.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_bank][wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/cp_inserter.sv
// cp_inserter
// Transmit cyclic-prefix inserter. Buffers N-sample symbols in a ping-pong
// store and emits, per symbol, the last CP samples followed by all N samples.
//   clk, rst              : clock, synchronous active-high reset
//   in_data/valid/ready   : IFFT sample stream in
//   out_data/valid/ready  : prefixed sample stream out
// Optional macro CPI_FLAGS_EN adds out_sos (first prefix beat), out_eos
// (last body beat) and out_in_cp (any prefix beat), aligned with out_data.
module cp_inserter
   import ofdm_tx_pkg::*;
#(
   parameter int D  = DEF_D,
   parameter int N  = DEF_N,
   parameter int CP = DEF_CP
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [D-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [D-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
`ifdef CPI_FLAGS_EN
   ,
   output logic         out_sos,
   output logic         out_eos,
   output logic         out_in_cp
`endif
);

   localparam int            AW        = $clog2(N);
   localparam logic [AW-1:0] PRE_START = AW'(N - CP);
   localparam logic [AW-1:0] PRE_NEXT  = AW'(N - CP + 1);
   localparam logic [AW-1:0] LAST_IDX  = AW'(N - 1);

   rd_state_t     state, next_state;
   logic [1:0]    full, full_next;
   logic          wbank, rbank;
   logic [AW-1:0] wptr, rptr, nxt_rptr;
   logic          wr_fire, set_full, out_fire;
   logic          ld, ld_bank, nxt_valid, clr_full;
   logic [AW-1:0] ld_addr;
   logic [D-1:0]  rd_data;

   cpi_symbol_buf #(.D(D), .N(N), .AW(AW)) u_buf (
      .clk     (clk),
      .we      (wr_fire),
      .wr_bank (wbank),
      .wr_addr (wptr),
      .wr_data (in_data),
      .rd_bank (ld_bank),
      .rd_addr (ld_addr),
      .rd_data (rd_data)
   );

   assign wr_fire  = in_valid && in_ready;
   assign set_full = wr_fire && (wptr == LAST_IDX);
   assign out_fire = out_valid && out_ready;

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. The pointer runs one ahead of the sample held in
   // out_data, so a pointer of 0 (wrapped) means index N-1 is being sent.
   always_comb begin
      next_state = state;
      nxt_rptr   = rptr;
      nxt_valid  = out_valid;
      ld         = 1'b0;
      ld_bank    = rbank;
      ld_addr    = rptr;
      clr_full   = 1'b0;
      case (state)
         IDLE: begin
            if (full[rbank]) begin
               ld         = 1'b1;
               ld_addr    = PRE_START;
               nxt_rptr   = PRE_NEXT;
               nxt_valid  = 1'b1;
               next_state = PREFIX;
            end else begin
               nxt_valid  = 1'b0;
            end
         end
         PREFIX: begin
            if (out_fire) begin
               ld = 1'b1;
               if (rptr == '0) begin
                  ld_addr    = '0;
                  nxt_rptr   = AW'(1);
                  next_state = BODY;
               end else begin
                  nxt_rptr   = rptr + 1'b1;
               end
            end
         end
         BODY: begin
            if (out_fire) begin
               if (rptr == '0) begin
                  clr_full = 1'b1;
                  // The other bank already holds a complete symbol: start its
                  // prefix on the very next beat so the stream has no gap.
                  if (full[~rbank]) begin
                     ld         = 1'b1;
                     ld_bank    = ~rbank;
                     ld_addr    = PRE_START;
                     nxt_rptr   = PRE_NEXT;
                     next_state = PREFIX;
                  end else begin
                     nxt_valid  = 1'b0;
                     next_state = IDLE;
                  end
               end else begin
                  ld       = 1'b1;
                  nxt_rptr = rptr + 1'b1;
               end
            end
         end
         default: begin
            nxt_valid  = 1'b0;
            next_state = IDLE;
         end
      endcase
   end

   // Output logic: the writer may fill its bank only while that bank is free.
   always_comb begin
      in_ready = !full[wbank];
   end

   // Bank flags; a clear is applied after a set so it wins on a collision.
   always_comb begin
      full_next = full;
      if (set_full) begin
         full_next[wbank] = 1'b1;
      end
      if (clr_full) begin
         full_next[rbank] = 1'b0;
      end
   end

   // Write side, read pointer and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         full      <= '0;
         wbank     <= 1'b0;
         rbank     <= 1'b0;
         wptr      <= '0;
         rptr      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         full      <= full_next;
         rptr      <= nxt_rptr;
         out_valid <= nxt_valid;
         if (ld) begin
            out_data <= rd_data;
         end
         if (wr_fire) begin
            wptr <= wptr + 1'b1;
            if (set_full) begin
               wbank <= ~wbank;
            end
         end
         if (clr_full) begin
            rbank <= ~rbank;
         end
      end
   end

   // Writer and reader touching the same flag in one cycle means the bank
   // bookkeeping has been corrupted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_flag_collision: assert (!(set_full && clr_full && (wbank == rbank)));
      end
   end

`ifdef CPI_FLAGS_EN
   // Markers travel with the sample they describe and hold with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_sos   <= 1'b0;
         out_eos   <= 1'b0;
         out_in_cp <= 1'b0;
      end else if (ld) begin
         out_sos   <= (next_state == PREFIX) && (ld_addr == PRE_START);
         out_eos   <= (next_state == BODY) && (ld_addr == LAST_IDX);
         out_in_cp <= (next_state == PREFIX);
      end else if (!nxt_valid) begin
         out_sos   <= 1'b0;
         out_eos   <= 1'b0;
         out_in_cp <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_cp_inserter.sv
// tb_cp_inserter
// Self-checking bench for cp_inserter: a default-size instance (N=64, CP=16)
// and a small instance (N=16, CP=4), each with a scoreboard fed from the
// accepted input samples. Define CPI_FLAGS_EN to also check the marker ports.
module tb_cp_inserter;

   localparam int D   = 16;
   localparam int N   = 64;
   localparam int CP  = 16;
   localparam int SN  = 16;
   localparam int SCP = 4;

   typedef struct {
      logic [D-1:0] data;
      logic         sos;
      logic         eos;
      logic         incp;
   } beat_t;

   logic         clk;
   logic         rst;
   logic [D-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [D-1:0] out_data;
   logic         out_valid;
   logic         out_ready;

   logic [D-1:0] s_in_data;
   logic         s_in_valid;
   logic         s_in_ready;
   logic [D-1:0] s_out_data;
   logic         s_out_valid;
   logic         s_out_ready;

`ifdef CPI_FLAGS_EN
   logic out_sos, out_eos, out_in_cp;
   logic s_out_sos, s_out_eos, s_out_in_cp;
`endif

   beat_t        exp_q[$];
   logic [D-1:0] part[$];
   logic [D-1:0] s_exp_q[$];
   logic [D-1:0] s_part[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fires = 0;
   int s_fires = 0;
   int sym_done_edge = 0;
   int sos_cnt = 0;
   int eos_cnt = 0;
   int cp_cnt = 0;

   cp_inserter #(.D(D), .N(N), .CP(CP)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef CPI_FLAGS_EN
      ,
      .out_sos   (out_sos),
      .out_eos   (out_eos),
      .out_in_cp (out_in_cp)
`endif
   );

   cp_inserter #(.D(D), .N(SN), .CP(SCP)) dut_small (
      .clk       (clk),
      .rst       (rst),
      .in_data   (s_in_data),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .out_data  (s_out_data),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready)
`ifdef CPI_FLAGS_EN
      ,
      .out_sos   (s_out_sos),
      .out_eos   (s_out_eos),
      .out_in_cp (s_out_in_cp)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] simulation stopped by watchdog");
   end

   // Scoreboard for the default instance: builds the expected beats of each
   // symbol as it is accepted, compares on every output transfer, and checks
   // that a stalled beat holds.
   initial begin
      beat_t        e;
      logic [D-1:0] held_data;
      logic [2:0]   held_flags;
      bit           pend;
      pend       = 1'b0;
      held_data  = '0;
      held_flags = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            part.delete();
            exp_q.delete();
            pend = 1'b0;
         end else begin
            if (pend) begin
               checks++;
               if (out_valid !== 1'b1 || out_data !== held_data) begin
                  errors++;
                  $display("[TB] FAIL hold: valid=%b data=%0d, required valid=1 data=%0d",
                           out_valid, out_data, held_data);
               end
`ifdef CPI_FLAGS_EN
               checks++;
               if ({out_sos, out_eos, out_in_cp} !== held_flags) begin
                  errors++;
                  $display("[TB] FAIL hold_flags: got %b, required %b",
                           {out_sos, out_eos, out_in_cp}, held_flags);
               end
`endif
            end
            pend      = out_valid && !out_ready;
            held_data = out_data;
`ifdef CPI_FLAGS_EN
            held_flags = {out_sos, out_eos, out_in_cp};
`endif
            if (out_valid && out_ready) begin
               fires++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL unexpected_beat: got data=%0d, required no output", out_data);
               end else begin
                  e = exp_q.pop_front();
                  if (out_data !== e.data) begin
                     errors++;
                     $display("[TB] FAIL out_data: got %0d, required %0d", out_data, e.data);
                  end
`ifdef CPI_FLAGS_EN
                  checks++;
                  if ({out_sos, out_eos, out_in_cp} !== {e.sos, e.eos, e.incp}) begin
                     errors++;
                     $display("[TB] FAIL flags: sos/eos/cp got %b, required %b",
                              {out_sos, out_eos, out_in_cp}, {e.sos, e.eos, e.incp});
                  end
                  if (out_sos)   sos_cnt++;
                  if (out_eos)   eos_cnt++;
                  if (out_in_cp) cp_cnt++;
`endif
               end
            end
            if (in_valid && in_ready) begin
               part.push_back(in_data);
               if (part.size() == N) begin
                  for (int j = 0; j < CP; j++) begin
                     e.data = part[N-CP+j];
                     e.sos  = (j == 0);
                     e.eos  = 1'b0;
                     e.incp = 1'b1;
                     exp_q.push_back(e);
                  end
                  for (int j = 0; j < N; j++) begin
                     e.data = part[j];
                     e.sos  = 1'b0;
                     e.eos  = (j == N-1);
                     e.incp = 1'b0;
                     exp_q.push_back(e);
                  end
                  part.delete();
                  sym_done_edge = cyc + 1;
               end
            end
         end
      end
   end

   // Scoreboard for the small instance.
   initial begin
      logic [D-1:0] se;
      forever begin
         @(negedge clk);
         if (rst) begin
            s_part.delete();
            s_exp_q.delete();
         end else begin
            if (s_out_valid && s_out_ready) begin
               s_fires++;
               checks++;
               if (s_exp_q.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL small_unexpected_beat: got data=%0d, required no output", s_out_data);
               end else begin
                  se = s_exp_q.pop_front();
                  if (s_out_data !== se) begin
                     errors++;
                     $display("[TB] FAIL small_out_data: got %0d, required %0d", s_out_data, se);
                  end
               end
            end
            if (s_in_valid && s_in_ready) begin
               s_part.push_back(s_in_data);
               if (s_part.size() == SN) begin
                  for (int j = 0; j < SCP; j++) s_exp_q.push_back(s_part[SN-SCP+j]);
                  for (int j = 0; j < SN; j++)  s_exp_q.push_back(s_part[j]);
                  s_part.delete();
               end
            end
         end
      end
   end

   // Drives count samples base, base+1, ... on the default instance.
   // Entered and left one time unit after a rising edge.
   task automatic drive_samples(input int base, input int count);
      int guard;
      for (int i = 0; i < count; i++) begin
         in_data  = D'(base + i);
         in_valid = 1'b1;
         guard    = 0;
         @(negedge clk);
         while (!in_ready && guard < 1000) begin
            guard++;
            @(negedge clk);
         end
         if (guard >= 1000) begin
            errors++;
            checks++;
            $display("[TB] FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || out_valid) && g < 5000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 5000) begin
         errors++;
         checks++;
         $display("[TB] FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid);
      end
      checks++;
      if (out_data !== '0) begin
         errors++;
         $display("[TB] FAIL reset_out_data: got %0d, required 0", out_data);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      checks++;
      if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_small: valid=%b ready=%b, required valid=0 ready=1",
                  s_out_valid, s_in_ready);
      end
`ifdef CPI_FLAGS_EN
      checks++;
      if ({out_sos, out_eos, out_in_cp} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b, required 000", {out_sos, out_eos, out_in_cp});
      end
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_single();
      int f0, g, first_cyc;
      $display("[TB] single symbol");
      out_ready = 1'b1;
      f0 = fires;
      drive_samples(0, N);
      g = 0;
      @(negedge clk);
      while (!out_valid && g < 100) begin
         g++;
         @(negedge clk);
      end
      first_cyc = cyc;
      checks++;
      if (first_cyc !== sym_done_edge + 1) begin
         errors++;
         $display("[TB] FAIL latency: first valid after edge %0d, required edge %0d",
                  first_cyc, sym_done_edge + 1);
      end
      @(posedge clk);
      #1;
      wait_drain();
      checks++;
      if (fires - f0 !== CP + N) begin
         errors++;
         $display("[TB] FAIL single_beats: got %0d, required %0d", fires - f0, CP + N);
      end
   endtask

   task automatic test_back_to_back();
      int g, bubbles, stalls, f0;
      $display("[TB] three back-to-back symbols");
      out_ready = 1'b1;
      bubbles   = 0;
      stalls    = 0;
      f0        = fires;
      fork
         begin
            drive_samples(100, N);
            drive_samples(200, N);
            drive_samples(300, N);
         end
         begin
            g = 0;
            @(negedge clk);
            while (!out_valid && g < 300) begin
               g++;
               @(negedge clk);
            end
            for (int b = 0; b < 3 * (CP + N); b++) begin
               if (!out_valid) bubbles++;
               if (in_valid && !in_ready) stalls++;
               @(negedge clk);
            end
            checks++;
            if (bubbles !== 0) begin
               errors++;
               $display("[TB] FAIL b2b_bubbles: got %0d idle beats, required 0", bubbles);
            end
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("[TB] FAIL b2b_tail: out_valid=%b after 240 beats, required 0", out_valid);
            end
         end
      join
      checks++;
      if (stalls == 0) begin
         errors++;
         $display("[TB] FAIL b2b_backpressure: in_ready low for %0d cycles, required >0", stalls);
      end
      wait_drain();
      checks++;
      if (fires - f0 !== 3 * (CP + N)) begin
         errors++;
         $display("[TB] FAIL b2b_beats: got %0d, required %0d", fires - f0, 3 * (CP + N));
      end
   endtask

   task automatic test_random_ready();
      bit done;
      int g;
      $display("[TB] random out_ready");
      done = 1'b0;
      fork
         begin
            drive_samples(1000, N);
            drive_samples(2000, N);
            done = 1'b1;
         end
         begin
            g = 0;
            while (!(done && exp_q.size() == 0 && !out_valid) && g < 3000) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
               g++;
            end
            if (g >= 3000) begin
               errors++;
               checks++;
               $display("[TB] FAIL random_timeout: %0d beats outstanding, required 0", exp_q.size());
            end
            out_ready = 1'b1;
         end
      join
      @(posedge clk);
      #1;
   endtask

   task automatic test_mid_reset();
      $display("[TB] reset mid-symbol");
      out_ready = 1'b1;
      drive_samples(3000, N);
      drive_samples(4000, 30);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_out_valid: got %b, required 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_in_ready: got %b, required 1", in_ready);
      end
      @(posedge clk);
      #1;
      drive_samples(5000, N);
      wait_drain();
   endtask

   task automatic test_param();
      int g;
      $display("[TB] small instance N=16 CP=4");
      s_out_ready = 1'b1;
      for (int i = 0; i < SN; i++) begin
         s_in_data  = D'(i);
         s_in_valid = 1'b1;
         g          = 0;
         @(negedge clk);
         while (!s_in_ready && g < 200) begin
            g++;
            @(negedge clk);
         end
         @(posedge clk);
         #1;
      end
      s_in_valid = 1'b0;
      g = 0;
      while ((s_exp_q.size() != 0 || s_out_valid) && g < 500) begin
         @(negedge clk);
         g++;
      end
      checks++;
      if (s_fires !== SCP + SN) begin
         errors++;
         $display("[TB] FAIL small_beats: got %0d, required %0d", s_fires, SCP + SN);
      end
      @(posedge clk);
      #1;
   endtask

`ifdef CPI_FLAGS_EN
   task automatic test_flags();
      int s0, e0, c0;
      $display("[TB] marker flags");
      s0 = sos_cnt;
      e0 = eos_cnt;
      c0 = cp_cnt;
      out_ready = 1'b1;
      drive_samples(7000, N);
      wait_drain();
      checks++;
      if (sos_cnt - s0 !== 1 || eos_cnt - e0 !== 1 || cp_cnt - c0 !== CP) begin
         errors++;
         $display("[TB] FAIL flag_counts: sos=%0d eos=%0d cp=%0d, required 1 1 %0d",
                  sos_cnt - s0, eos_cnt - e0, cp_cnt - c0, CP);
      end
   endtask
`endif

   initial begin
      rst         = 1'b1;
      in_data     = '0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      s_in_data   = '0;
      s_in_valid  = 1'b0;
      s_out_ready = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_random_ready();
      test_mid_reset();
      test_param();
`ifdef CPI_FLAGS_EN
      test_flags();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
